drive_head_ctl: RTL and testbench
=================================

Name: drive_head_ctl

Overview:
Parametrised head-positioning and dirty-track flush controller for the c15xx drive family (1541, and 1571 with two heads). It decodes stepper-phase transitions from the drive logic into a clamped half-track position and selects the active head. It flags tracks modified by the GCR engine and issues queued save requests to the SD track buffer over a req/ack handshake. It sits between the drive logic/GCR blocks and the SD track-buffer block, replacing the inline stepper logic in the drive top level.

Parameters:
MAX_HT, 80, highest half-track number; 84 allows 42 tracks.
INIT_HT, 36, half-track loaded on reset (track 18).
HEADS, 1, head count, 1 or 2; with 1, head_sel is ignored and head reads 0.
SETTLE, 1000, number of ce cycles for which ready is low after any step or head change.
TW, 6, track output width; must satisfy 2^TW > MAX_HT/2.

Ports:
clk_c1541  in  1  drive clock; the only clock.
reset  in  1  synchronous, active-high.
ce  in  1  clock enable; all state advances only when ce=1, except the ack sampling rule below.
mtr  in  1  spindle motor on; steps are decoded only when mtr=1.
stp  in  2  stepper phase from the drive VIA.
act  in  1  activity LED; its falling edge triggers a flush.
head_sel  in  1  requested head (side), used only when HEADS=2.
buff_we  in  1  GCR write strobe into the track buffer.
disk_change  in  1  level input; while high, dirty and queue state are discarded.
track  out  TW  current track, equal to ht[TW:1].
ht  out  TW+1  current half-track.
head  out  1  current head.
tr00_sense_n  out  1  0 when track==0.
ready  out  1  1 when the head has settled.
save_req  out  1  save request to the track buffer.
save_track  out  TW  track to save; stable while save_req=1.
save_head  out  1  head to save; stable while save_req=1.
save_ack  in  1  one-cycle acknowledge from the track buffer, on clk_c1541.
ovf  out  1  sticky flush-overflow flag; cleared only by reset.

Behaviour:
- Reset values:
  - ht=INIT_HT, head=0, ready=1, save_req=0, save_track=0, save_head=0, ovf=0.
  - dirty=0, queue empty.
  - stp_r is loaded from stp so that no step is decoded on the first cycle.
- Step decode, evaluated on ce cycles with mtr=1 against the registered stp_r:
  - Inward sequence: 0→2, 2→1, 1→3, 3→0. Each increments ht, saturating at MAX_HT.
  - Outward sequence: 0→3, 2→0, 1→2, 3→1. Each decrements ht, saturating at 1.
  - Opposite-phase jumps (0↔1, 2↔3) and unchanged phase are ignored.
  - stp_r updates on every ce cycle regardless of mtr.
- Latency: a new ht value is visible one cycle after the decoding ce cycle. track and tr00_sense_n are combinational from ht.
- Head change: when HEADS=2 and head_sel≠head on a ce cycle, head takes the new value on the next cycle.
- Dirty tracking:
  - A ce cycle with buff_we=1 sets dirty.
  - disk_change=1 forces dirty=0, empties the queue and drops save_req.
  - A save_req handshake already in flight is dropped without waiting for ack.
- Flush events: an actual ht change (saturated steps do not count), a head change, or a falling edge of act (registered on ce). For each event:
  - If dirty=1: push {old track, old head} (values before the event), then clear dirty in the same cycle.
  - If buff_we and a flush event occur in the same cycle, the push happens and dirty stays set for the new track.
- Queue: two entries, FIFO order.
  - save_req=1 whenever the queue is non-empty; save_track and save_head show the head entry.
  - save_ack while save_req=1 pops the entry in that cycle, regardless of ce. save_req may stay high for the next entry with no gap.
  - save_ack while save_req=0 is ignored.
  - A push to a full queue is dropped and sets ovf.
  - A simultaneous push and pop when full is accepted.
- Settle: any ht or head change loads a counter with SETTLE and drops ready to 0. The counter decrements on ce cycles. ready returns to 1 on the ce cycle where the counter reaches 0. A new step reloads the counter.
- Reset asserted mid-handshake abandons the request; save_req falls the cycle after reset.

Test Plan:
1. Reset, then mtr=1, stp sequence 0,2,1,3,0 with ce always high → ht goes 36,37,38,39,40; track goes 18,18,19,19,20; ready low for SETTLE cycles after each step.
2. ht=2, outward sequence repeated 4 times → ht saturates at 1, track=0, tr00_sense_n=0; no flush events are generated once saturated.
3. A buff_we pulse at ht=36, then one inward step → save_req=1 with save_track=18; hold off save_ack for 50 cycles → save_track stays 18; ack → save_req=0 next cycle.
4. Three dirty flush events with ack held off (writes at track 18, step, write, step, write, act fall) → queue holds 18 and 19; ovf=1; ack twice → save_track 18 then 19, then save_req=0.
5. HEADS=2: write on head 0, head_sel=1 → save_head=0, save_track=18, head=1, ready low for SETTLE cycles.
6. disk_change pulse while save_req=1 with a dirty track → save_req=0 next cycle, dirty cleared; a following step with no writes produces no request.

Source files
------------

// File: rtl/drive_head_ctl.sv
// rtl/drive_head_ctl.sv - c15xx head positioning and dirty-track flush controller
//
// Decodes stepper phase transitions into a clamped half-track position,
// tracks the active head, marks tracks written by the GCR engine as dirty
// and queues {track, head} save requests to the SD track buffer.
//
// Ports:
//   clk_c1541, reset    clock and synchronous active-high reset
//   ce                  clock enable for all state except save_ack handling
//   mtr, stp            motor on and stepper phases from the drive VIA
//   act                 activity LED, falling edge requests a flush
//   head_sel            requested head (HEADS=2 only)
//   buff_we             GCR write strobe, marks current track dirty
//   disk_change         discards dirty and queued state while high
//   track, ht, head     current position and head
//   tr00_sense_n        low on track 0
//   ready               high once the head has settled
//   save_req/track/head save request and queue head entry
//   save_ack            one-cycle acknowledge, pops the queue
//   ovf                 sticky flag, a save request was lost to a full queue
module drive_head_ctl #(
   parameter int MAX_HT  = 80,
   parameter int INIT_HT = 36,
   parameter int HEADS   = 1,
   parameter int SETTLE  = 1000,
   parameter int TW      = 6
) (
   input  logic          clk_c1541,
   input  logic          reset,
   input  logic          ce,
   input  logic          mtr,
   input  logic [1:0]    stp,
   input  logic          act,
   input  logic          head_sel,
   input  logic          buff_we,
   input  logic          disk_change,
   output logic [TW-1:0] track,
   output logic [TW:0]   ht,
   output logic          head,
   output logic          tr00_sense_n,
   output logic          ready,
   output logic          save_req,
   output logic [TW-1:0] save_track,
   output logic          save_head,
   input  logic          save_ack,
   output logic          ovf
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam logic [TW:0]   MAX_V    = (TW+1)'(MAX_HT);
   localparam logic [TW:0]   INIT_V   = (TW+1)'(INIT_HT);
   localparam logic [TW:0]   ONE_V    = (TW+1)'(1);
   localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
   localparam logic [SW-1:0] CNT_ONE  = SW'(1);

   logic [1:0]    stp_r;
   logic          act_r;
   logic          dirty;
   logic [SW-1:0] settle_cnt;
   logic [1:0]    q_cnt;
   logic [TW-1:0] q_track0, q_track1;
   logic          q_head0, q_head1;

   logic step_in, step_out;
   logic ht_up, ht_dn, head_chg, act_fall, flush_ev, push, pop;

   // Phase sequence 0,2,1,3 moves inward; the reverse moves outward.
   always_comb begin
      step_in  = 1'b0;
      step_out = 1'b0;
      case ({stp_r, stp})
         4'b00_10, 4'b10_01, 4'b01_11, 4'b11_00: step_in  = 1'b1;
         4'b00_11, 4'b10_00, 4'b01_10, 4'b11_01: step_out = 1'b1;
         default: ;
      endcase
   end

   // Only real position changes count; saturated steps are no-ops.
   assign ht_up    = ce & mtr & step_in  & (ht < MAX_V);
   assign ht_dn    = ce & mtr & step_out & (ht > ONE_V);
   assign head_chg = ce & (HEADS == 2) & (head_sel != head);
   assign act_fall = ce & act_r & ~act;
   assign flush_ev = ht_up | ht_dn | head_chg | act_fall;
   assign push     = flush_ev & dirty;
   assign pop      = save_ack & (q_cnt != 2'd0);

   assign track        = ht[TW:1];
   assign tr00_sense_n = (track != '0);
   assign save_req     = (q_cnt != 2'd0);
   assign save_track   = q_track0;
   assign save_head    = q_head0;

   always_ff @(posedge clk_c1541) begin
      if (reset) begin
         stp_r      <= stp;
         act_r      <= act;
         ht         <= INIT_V;
         head       <= 1'b0;
         ready      <= 1'b1;
         settle_cnt <= '0;
         dirty      <= 1'b0;
         q_cnt      <= 2'd0;
         q_track0   <= '0;
         q_track1   <= '0;
         q_head0    <= 1'b0;
         q_head1    <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         if (ce) begin
            stp_r <= stp;
            act_r <= act;
         end

         if (ht_up)
            ht <= ht + 1'b1;
         else if (ht_dn)
            ht <= ht - 1'b1;

         if (head_chg)
            head <= head_sel;

         if (ht_up | ht_dn | head_chg) begin
            settle_cnt <= SETTLE_V;
            ready      <= (SETTLE == 0);
         end else if (ce && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
            if (settle_cnt == CNT_ONE)
               ready <= 1'b1;
         end

         if (disk_change) begin
            dirty <= 1'b0;
            q_cnt <= 2'd0;
         end else begin
            // A write in the same cycle as a flush keeps the new track dirty.
            if (ce & buff_we)
               dirty <= 1'b1;
            else if (push)
               dirty <= 1'b0;

            // Pushed entry captures track/head as they were before the event.
            if (push && pop) begin
               if (q_cnt == 2'd1) begin
                  q_track0 <= track;
                  q_head0  <= head;
               end else begin
                  q_track0 <= q_track1;
                  q_head0  <= q_head1;
                  q_track1 <= track;
                  q_head1  <= head;
               end
            end else if (pop) begin
               q_track0 <= q_track1;
               q_head0  <= q_head1;
               q_cnt    <= q_cnt - 2'd1;
            end else if (push) begin
               if (q_cnt == 2'd0) begin
                  q_track0 <= track;
                  q_head0  <= head;
                  q_cnt    <= 2'd1;
               end else if (q_cnt == 2'd1) begin
                  q_track1 <= track;
                  q_head1  <= head;
                  q_cnt    <= 2'd2;
               end else begin
                  ovf <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_drive_head_ctl.sv
// tb/tb_drive_head_ctl.sv - directed self-checking bench for drive_head_ctl
module tb_drive_head_ctl;

   localparam int TW     = 6;
   localparam int SETTLE = 8;

   logic          clk_c1541 = 1'b0;
   logic          reset = 1'b1;
   logic          ce = 1'b1;
   logic          mtr = 1'b0;
   logic [1:0]    stp = 2'd0;
   logic          act = 1'b0;
   logic          head_sel = 1'b0;
   logic          buff_we = 1'b0;
   logic          disk_change = 1'b0;
   logic          save_ack = 1'b0;
   logic [TW-1:0] track;
   logic [TW:0]   ht;
   logic          head;
   logic          tr00_sense_n;
   logic          ready;
   logic          save_req;
   logic [TW-1:0] save_track;
   logic          save_head;
   logic          ovf;

   int checks = 0;
   int errors = 0;

   drive_head_ctl #(
      .MAX_HT(80), .INIT_HT(36), .HEADS(2), .SETTLE(SETTLE), .TW(TW)
   ) dut (
      .clk_c1541(clk_c1541), .reset(reset), .ce(ce), .mtr(mtr), .stp(stp),
      .act(act), .head_sel(head_sel), .buff_we(buff_we),
      .disk_change(disk_change), .track(track), .ht(ht), .head(head),
      .tr00_sense_n(tr00_sense_n), .ready(ready), .save_req(save_req),
      .save_track(save_track), .save_head(save_head), .save_ack(save_ack),
      .ovf(ovf)
   );

   always #5 clk_c1541 = ~clk_c1541;

   task automatic tick();
      @(posedge clk_c1541);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] next_in(input logic [1:0] p);
      case (p)
         2'd0: return 2'd2;
         2'd2: return 2'd1;
         2'd1: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] next_out(input logic [1:0] p);
      case (p)
         2'd0: return 2'd3;
         2'd3: return 2'd1;
         2'd1: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   task automatic step_in_once();
      stp = next_in(stp);
      tick();
   endtask

   task automatic step_out_once();
      stp = next_out(stp);
      tick();
   endtask

   task automatic write_pulse();
      buff_we = 1'b1;
      tick();
      buff_we = 1'b0;
   endtask

   task automatic ack_pulse();
      save_ack = 1'b1;
      tick();
      save_ack = 1'b0;
   endtask

   // Called right after the cycle that started settling.
   task automatic settle_check(input string tag);
      check({tag, "_ready_drop"}, ready, 0);
      repeat (SETTLE - 1) tick();
      check({tag, "_ready_low"}, ready, 0);
      tick();
      check({tag, "_ready_back"}, ready, 1);
   endtask

   initial begin
      int exp_ht[4];
      int exp_tr[4];
      exp_ht = '{37, 38, 39, 40};
      exp_tr = '{18, 19, 19, 20};

      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("rst_ht", ht, 36);
      check("rst_track", track, 18);
      check("rst_head", head, 0);
      check("rst_ready", ready, 1);
      check("rst_save_req", save_req, 0);
      check("rst_save_track", save_track, 0);
      check("rst_ovf", ovf, 0);
      check("rst_tr00", tr00_sense_n, 1);

      // Steps ignored with motor off.
      stp = 2'd2;
      tick();
      check("mtr_off_ht", ht, 36);
      stp = 2'd0;
      tick();

      // Inward steps 0,2,1,3,0.
      mtr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step_in_once();
         check("in_ht", ht, exp_ht[i]);
         check("in_track", track, exp_tr[i]);
         settle_check("in");
      end

      // Opposite-phase jump is ignored.
      stp = 2'd1;
      tick();
      check("jump_ht", ht, 40);
      stp = 2'd0;
      tick();

      // Outward to half-track 2, then saturate at 1.
      repeat (38) step_out_once();
      check("out_ht2", ht, 2);
      repeat (16) step_out_once();
      check("sat_ht", ht, 1);
      check("sat_track", track, 0);
      check("sat_tr00", tr00_sense_n, 0);
      repeat (SETTLE + 2) tick();
      write_pulse();
      repeat (4) step_out_once();
      check("sat_no_flush", save_req, 0);
      check("sat_ready", ready, 1);
      check("sat_ht2", ht, 1);
      disk_change = 1'b1;
      tick();
      disk_change = 1'b0;

      // Single dirty flush with ack held off.
      repeat (35) step_in_once();
      check("back_ht36", ht, 36);
      write_pulse();
      step_in_once();
      check("t3_ht", ht, 37);
      check("t3_req", save_req, 1);
      check("t3_track", save_track, 18);
      repeat (50) tick();
      check("t3_hold_req", save_req, 1);
      check("t3_hold_track", save_track, 18);
      ack_pulse();
      check("t3_ack_req", save_req, 0);
      ack_pulse();
      check("t3_stray_ack", save_req, 0);

      // Three flushes into a two-entry queue.
      write_pulse();
      step_in_once();
      write_pulse();
      step_in_once();
      check("t4_ht", ht, 39);
      write_pulse();
      act = 1'b1;
      tick();
      act = 1'b0;
      tick();
      check("t4_req", save_req, 1);
      check("t4_track0", save_track, 18);
      check("t4_ovf", ovf, 1);
      ack_pulse();
      check("t4_req1", save_req, 1);
      check("t4_track1", save_track, 19);
      ack_pulse();
      check("t4_empty", save_req, 0);
      check("t4_ovf_sticky", ovf, 1);

      // Head change flushes the old head's track.
      write_pulse();
      head_sel = 1'b1;
      tick();
      check("t5_head", head, 1);
      check("t5_req", save_req, 1);
      check("t5_save_head", save_head, 0);
      check("t5_save_track", save_track, 19);
      settle_check("t5");
      ack_pulse();
      check("t5_empty", save_req, 0);

      // disk_change drops queue and dirty state.
      write_pulse();
      step_in_once();
      check("t6_req", save_req, 1);
      check("t6_save_head", save_head, 1);
      check("t6_save_track", save_track, 19);
      write_pulse();
      disk_change = 1'b1;
      tick();
      disk_change = 1'b0;
      check("t6_dc_req", save_req, 0);
      step_in_once();
      check("t6_ht", ht, 41);
      check("t6_no_req", save_req, 0);

      // Reset mid-handshake abandons the request.
      write_pulse();
      step_in_once();
      check("t7_req", save_req, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t7_rst_req", save_req, 0);
      check("t7_rst_ht", ht, 36);
      check("t7_rst_head", head, 0);
      check("t7_rst_ovf", ovf, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
